// File: rtl/uart_rom_loader_if.sv
// ROM write port plus boot-control/status bundle driven by the UART loader.
interface uart_rom_loader_if #(
  parameter int ADDR_W = 12
);
  logic              rom_we_o;
  logic [ADDR_W-1:0] rom_waddr_o;
  logic [31:0]       rom_wdata_o;
  logic              core_rst_n_o;
  logic              load_busy_o;
  logic              load_done_o;
  logic              load_err_o;

  modport master (
    output rom_we_o, rom_waddr_o, rom_wdata_o,
    output core_rst_n_o, load_busy_o, load_done_o, load_err_o
  );

  modport slave (
    input rom_we_o, rom_waddr_o, rom_wdata_o,
    input core_rst_n_o, load_busy_o, load_done_o, load_err_o
  );
endinterface

// File: rtl/uart_rom_loader.sv
// UART boot loader: receives an 0xA5 / count / data frame over 8N1 serial and
// writes the words into the instruction ROM from address 0, holding the core
// in reset while the image is incomplete.
module uart_rom_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  uart_rom_loader_if.master bus
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]       HDR      = 8'hA5;

  // ---------------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;

  // [0],[1] form the synchronizer, [2] is the previous synchronized sample
  logic [2:0]       rx_pipe;
  logic             rx_s, rx_prev;
  rx_st_t           rx_st;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_shift;
  logic             byte_valid, frame_err;

  assign rx_s    = rx_pipe[1];
  assign rx_prev = rx_pipe[2];

  // Synchronize the serial line; reset to idle-high so no false start edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_pipe <= '1;
    else      rx_pipe <= {rx_pipe[1:0], uart_rx};
  end

  // Bit timer: start bit checked mid-bit, then data/stop sampled each bit period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_st      <= RX_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_st)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_st   <= RX_START;
            bit_cnt <= '0;
          end
        end
        RX_START: begin
          if (bit_cnt == HALF_END) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            // a line already back high at mid-start is a glitch
            rx_st   <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (bit_cnt == BIT_END) begin
            bit_cnt  <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_st <= RX_STOP;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (bit_cnt == BIT_END) begin
            bit_cnt <= '0;
            rx_st   <= RX_IDLE;
            if (rx_s) byte_valid <= 1'b1;
            else      frame_err  <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Frame loader
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, DONE_ST, ERR_ST} ld_st_t;

  ld_st_t            st;
  logic [7:0]        cnt_lo;
  logic [ADDR_W:0]   n_words;
  logic [ADDR_W:0]   word_cnt;
  logic [ADDR_W:0]   word_cnt_nxt;
  logic [1:0]        byte_idx;
  logic [31:0]       asm_w;
  logic [31:0]       asm_nxt;
  logic [15:0]       cnt_full;
  logic              cnt_ovf;
  logic              rom_we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              core_rst_n, busy, done, err;

  // Word counter is one bit wider than the address so a full-depth image fits
  assign word_cnt_nxt = word_cnt + (ADDR_W+1)'(1);
  assign asm_nxt      = {rx_shift, asm_w[31:8]};
  assign cnt_full     = {rx_shift, cnt_lo};
  assign cnt_ovf      = 33'(cnt_full) > (33'd1 << ADDR_W);

  // Frame parser with registered ROM strobe and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st         <= IDLE;
      cnt_lo     <= '0;
      n_words    <= '0;
      word_cnt   <= '0;
      byte_idx   <= '0;
      asm_w      <= '0;
      rom_we     <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      core_rst_n <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      rom_we <= 1'b0;
      // address advances on the edge after the strobe, wrapping after the last word
      if (rom_we) waddr <= waddr + ADDR_W'(1);
      case (st)
        IDLE: begin
          if (byte_valid && rx_shift == HDR) begin
            st         <= CNT_LO;
            done       <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b1;
            core_rst_n <= 1'b0;
            waddr      <= '0;
            word_cnt   <= '0;
            byte_idx   <= '0;
          end
        end
        CNT_LO: begin
          if (frame_err) st <= ERR_ST;
          else if (byte_valid) begin
            cnt_lo <= rx_shift;
            st     <= CNT_HI;
          end
        end
        CNT_HI: begin
          if (frame_err) st <= ERR_ST;
          else if (byte_valid) begin
            if (cnt_full == 16'd0) begin
              // empty image completes immediately
              st         <= DONE_ST;
              done       <= 1'b1;
              busy       <= 1'b0;
              core_rst_n <= 1'b1;
            end else if (cnt_ovf) begin
              st <= ERR_ST;
            end else begin
              n_words <= (ADDR_W+1)'(cnt_full);
              st      <= DATA;
            end
          end
        end
        DATA: begin
          if (frame_err) st <= ERR_ST;
          else if (byte_valid) begin
            asm_w    <= asm_nxt;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              rom_we   <= 1'b1;
              wdata    <= asm_nxt;
              word_cnt <= word_cnt_nxt;
              if (word_cnt_nxt == n_words) st <= DONE_ST;
            end
          end
        end
        DONE_ST: begin
          done       <= 1'b1;
          busy       <= 1'b0;
          core_rst_n <= 1'b1;
          st         <= IDLE;
        end
        ERR_ST: begin
          // partial image: core stays held in reset
          err  <= 1'b1;
          busy <= 1'b0;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.rom_we_o     = rom_we;
  assign bus.rom_waddr_o  = waddr;
  assign bus.rom_wdata_o  = wdata;
  assign bus.core_rst_n_o = core_rst_n;
  assign bus.load_busy_o  = busy;
  assign bus.load_done_o  = done;
  assign bus.load_err_o   = err;

endmodule
